philv_trace_unit: RTL and testbench
===================================

# philv_trace_unit

Hardware run controller and trace capture for the Philosophy V core. It gates the core's clock enable to run for a programmed number of cycles, or to single-step one cycle. On every enabled cycle it snapshots the core's controller state, PC and fetched instruction into a circular FIFO. A valid/ready port drains the records to a host-side consumer. It sits beside `philosophy_v_core` in the SoC top and drives the core's cycle enable.

## Interface
Parameters:
- `PC_W`, 32, PC width
- `INSTR_W`, 32, instruction width
- `STATE_W`, 4, main-controller state width
- `DEPTH_LOG2`, 4, FIFO depth = 2^DEPTH_LOG2 records

Ports:
- `clk`  in  1  sole clock, rising edge
- `rstb`  in  1  reset, synchronous, active-low
- `start`  in  1  pulse; begin a run of `num_cycles` cycles
- `num_cycles`  in  16  run length, sampled on the accepted `start`
- `step`  in  1  pulse; run exactly one core cycle
- `halt`  in  1  abort the current run
- `core_en`  out  1  core cycle enable
- `state_in`  in  STATE_W  core controller state
- `pc_in`  in  PC_W  core PC (IF register)
- `instr_in`  in  INSTR_W  instruction-memory read data
- `rec_valid`  out  1  FIFO non-empty
- `rec_ready`  in  1  consumer accepts the head record
- `rec_cycle`  out  16  cycle index of the head record
- `rec_state`  out  STATE_W  head record field
- `rec_pc`  out  PC_W  head record field
- `rec_instr`  out  INSTR_W  head record field
- `busy`  out  1  FSM is not in IDLE
- `done`  out  1  one-cycle pulse at the end of a run or step
- `overflow`  out  1  sticky; at least one record was dropped (DROP build only)

## Operation
FSM states and transitions:
- IDLE
  - `start` with `num_cycles`=0 -> DONE
  - `start` with `num_cycles`≠0 -> RUN; load `remaining`=`num_cycles`
  - `step` -> STEP
  - `start` wins over `step` when both are asserted
- RUN: `core_en`=!full.
  - Each enabled cycle writes one record and decrements `remaining`.
  - On the enabled cycle where `remaining`=1 -> DONE.
  - `halt` -> DONE immediately; `core_en`=0 in the halt cycle.
- STEP: `core_en`=!full.
  - One enabled cycle writes one record -> DONE.
  - While the FIFO is full, stay in STEP.
- DONE: `done`=1 for one cycle -> IDLE.
- `start` and `step` are ignored outside IDLE. `halt` is ignored outside RUN and STEP.

Records and cycle counter:
- Each record holds {`cycle_cnt`, `state_in`, `pc_in`, `instr_in`}, sampled at the rising edge that ends an enabled cycle.
- `cycle_cnt` is 16 bits and starts at 0 after reset. It increments once per enabled cycle, is never cleared by runs, and wraps 0xFFFF -> 0.

FIFO:
- Built from registered read/write pointers, each with one wrap bit.
- full = pointers equal except the wrap bit. empty = pointers fully equal.
- `rec_*` are driven combinationally from the head entry. A pop occurs when `rec_valid`&&`rec_ready`.
- When push and pop happen in the same cycle, both take effect and the count is unchanged.

Reset, with `rstb`=0 at a rising edge:
- FSM returns to IDLE. Pointers, `cycle_cnt`, `remaining` and `overflow` are cleared.
- Outputs after reset: `core_en`=0, `rec_valid`=0, `busy`=0, `done`=0, `overflow`=0.
- Reset mid-run discards all stored records.

## Timing
- `start` or `step` accepted at edge N: `core_en`=1 from cycle N+1, provided the FIFO is not full.
- The record captured at edge M is visible with `rec_valid`=1 in cycle M+1 (write-to-read latency of 1).
- Full is computed from registered pointers. A pop in the same cycle does not release the stall until the next cycle.
- A run of K cycles with no backpressure holds `core_en` for exactly K consecutive cycles; `done` pulses in cycle N+K+1.
- `halt` is combinational onto `core_en`: the halt cycle is not enabled and not recorded.

## Configuration
- `PHILV_TRACE_DROP_EN` defined:
  - `core_en` ignores FIFO full and is 1 for every RUN/STEP cycle.
  - A record arriving at a full FIFO is discarded and sets `overflow`.
  - `cycle_cnt` still advances, so gaps in `rec_cycle` reveal the lost records.
- Not defined:
  - Full stalls the core by holding `core_en`=0; no record is ever lost.
  - `overflow` is tied to 0.

## Test plan
- Reset, then `start` with `num_cycles`=5 and `rec_ready`=1 -> `core_en` high exactly 5 cycles; 5 records with `rec_cycle` 0..4 and PC matching `pc_in`; `done` one cycle after the last enabled cycle.
- `num_cycles`=40, DEPTH 16, `rec_ready`=0 -> 16 enabled cycles, then `core_en`=0, `busy`=1. Raise `rec_ready` -> run resumes; 40 records total with contiguous `rec_cycle`.
- Same stimulus with `PHILV_TRACE_DROP_EN` -> `core_en` high for 40 consecutive cycles; 16 records with `rec_cycle` 0..15; `overflow`=1.
- Three `step` pulses spaced 4 cycles apart -> three single-cycle `core_en` pulses, three records with `rec_cycle` 0,1,2, three `done` pulses.
- `start` with `num_cycles`=100, `halt` at the 10th enabled cycle -> that cycle has `core_en`=0; 9 records; `done` next cycle; a `start` during RUN is ignored.
- Reset asserted mid-run with 7 records pending -> next cycle `rec_valid`=0, `core_en`=0. A following `start` with `num_cycles`=1 records `rec_cycle`=0. Also run `num_cycles`=0 -> `done` with no `core_en`.

Source files
------------

// File: rtl/philv_trace_unit_if.sv
// Trace record drain port for philv_trace_unit.
// The master (the trace unit) presents the head FIFO record along with rec_valid.
// The slave (the host-side consumer) answers with rec_ready.
//   rec_valid  FIFO non-empty
//   rec_ready  consumer accepts the head record
//   rec_cycle  cycle index of the head record
//   rec_state  controller state field of the head record
//   rec_pc     PC field of the head record
//   rec_instr  instruction field of the head record
interface philv_trace_unit_if #(
  parameter int unsigned PC_W    = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned STATE_W = 4
);
  logic               rec_valid;
  logic               rec_ready;
  logic [15:0]        rec_cycle;
  logic [STATE_W-1:0] rec_state;
  logic [PC_W-1:0]    rec_pc;
  logic [INSTR_W-1:0] rec_instr;

  modport master (
    output rec_valid, rec_cycle, rec_state, rec_pc, rec_instr,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_cycle, rec_state, rec_pc, rec_instr,
    output rec_ready
  );
endinterface

// File: rtl/philv_trace_unit.sv
// Run controller and trace capture for the Philosophy V core.
// The unit gates the core cycle enable in two modes: a run of num_cycles cycles, or a
// single step. Each enabled cycle snapshots {cycle_cnt, state_in, pc_in, instr_in} into
// a circular FIFO. The FIFO drains through the rec interface (master side).
//
// Optional build macro PHILV_TRACE_DROP_EN:
//   - core_en ignores FIFO full.
//   - Records that arrive while the FIFO is full are discarded and set the sticky
//     overflow flag.
//   - Without the macro, a full FIFO stalls the core and overflow stays 0.
//
// Ports:
//   clk, rstb          clock, synchronous active-low reset
//   start, num_cycles  begin a run of num_cycles cycles (num_cycles is sampled with start)
//   step               run exactly one core cycle
//   halt               abort the current run or step (combinational onto core_en)
//   core_en            core cycle enable
//   state_in, pc_in,   core snapshot captured on each enabled cycle
//   instr_in
//   busy, done         FSM not idle / one-cycle end-of-run pulse
//   overflow           sticky record-dropped flag
//   rec                record drain port
module philv_trace_unit #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned STATE_W    = 4,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic [15:0]        num_cycles,
  input  logic               step,
  input  logic               halt,
  output logic               core_en,
  input  logic [STATE_W-1:0] state_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  philv_trace_unit_if.master rec
);

  localparam int unsigned RecW  = 16 + STATE_W + PC_W + INSTR_W;
  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PtrOne = 1;

  typedef enum logic [1:0] {StIdle, StRun, StStep, StDone} state_e;

  state_e                state_q;
  logic [15:0]           remaining_q;
  logic [15:0]           cycle_cnt_q;
  logic [DEPTH_LOG2:0]   wptr_q;
  logic [DEPTH_LOG2:0]   rptr_q;
  logic [RecW-1:0]       mem_q [Depth];
  logic [RecW-1:0]       head;

  logic full;
  logic empty;
  logic active;
  logic push;
  logic pop;

  assign full   = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                  (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign empty  = (wptr_q == rptr_q);
  assign active = (state_q == StRun) || (state_q == StStep);

`ifdef PHILV_TRACE_DROP_EN
  assign core_en = active && !halt;
  assign push    = core_en && !full;
`else
  assign core_en = active && !halt && !full;
  assign push    = core_en;
`endif

  assign pop  = !empty && rec.rec_ready;
  assign head = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  assign rec.rec_valid = !empty;
  assign {rec.rec_cycle, rec.rec_state, rec.rec_pc, rec.rec_instr} = head;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  // Storage has no reset; clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[DEPTH_LOG2-1:0]] <= {cycle_cnt_q, state_in, pc_in, instr_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= StIdle;
      remaining_q <= 16'd0;
      cycle_cnt_q <= 16'd0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrOne;
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrOne;
      end
      // cycle_cnt counts every enabled cycle, including any that are dropped.
      if (core_en) begin
        cycle_cnt_q <= cycle_cnt_q + 16'd1;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            if (num_cycles == 16'd0) begin
              state_q <= StDone;
            end else begin
              state_q     <= StRun;
              remaining_q <= num_cycles;
            end
          end else if (step) begin
            state_q <= StStep;
          end
        end
        StRun: begin
          if (halt) begin
            state_q <= StDone;
          end else if (core_en) begin
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state_q <= StDone;
            end
          end
        end
        StStep: begin
          if (halt || core_en) begin
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PHILV_TRACE_DROP_EN
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      overflow_q <= 1'b0;
    end else if (core_en && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_philv_trace_unit.sv
module tb_philv_trace_unit;

  localparam int DEPTH = 16;
`ifdef PHILV_TRACE_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MStep = 2;
  localparam int MDone = 3;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start;
  logic [15:0] num_cycles;
  logic        step;
  logic        halt;
  logic        core_en;
  logic [3:0]  state_in;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        busy;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  philv_trace_unit_if #(.PC_W(32), .INSTR_W(32), .STATE_W(4)) rif ();

  philv_trace_unit #(
    .PC_W(32), .INSTR_W(32), .STATE_W(4), .DEPTH_LOG2(4)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start), .num_cycles(num_cycles), .step(step),
    .halt(halt), .core_en(core_en), .state_in(state_in), .pc_in(pc_in),
    .instr_in(instr_in), .busy(busy), .done(done), .overflow(overflow), .rec(rif.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: run bookkeeping plus the list of records the FIFO should hold.
  int          mode = MIdle;
  int          remaining = 0;
  logic [15:0] cnt = 16'd0;
  bit          ovf = 1'b0;
  logic [83:0] exp_q[$];
  bit          exp_en = 1'b0;
  bit          exp_busy = 1'b0;
  bit          exp_done = 1'b0;
  bit          armed = 1'b0;
  int          en_seen = 0;
  int          rec_seen = 0;
  int          done_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs away from the active edge and pops accepted records.
  always @(negedge clk) begin
    if (armed) begin
      check("core_en", core_en, exp_en);
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      check("overflow", overflow, ovf);
      check("rec_valid", rif.rec_valid, exp_q.size() != 0);
      if (core_en) en_seen++;
      if (done) done_seen++;
      if (rif.rec_valid && rif.rec_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL record_extra: got cycle %0h, expected no record", rif.rec_cycle);
        end else begin
          check("record", {rif.rec_cycle, rif.rec_state, rif.rec_pc, rif.rec_instr},
                exp_q.pop_front());
          rec_seen++;
        end
      end
    end
  end

  // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
  task automatic tick(input bit st, input int n, input bit sp, input bit ht, input bit rdy,
                      input bit rb);
    bit active;
    bit full_now;
    logic [83:0] rec;
    rstb          = rb;
    start         = st;
    num_cycles    = 16'(n);
    step          = sp;
    halt          = ht;
    rif.rec_ready = rdy;
    state_in      = 4'($urandom);
    pc_in         = $urandom;
    instr_in      = $urandom;
    active   = (mode == MRun) || (mode == MStep);
    full_now = exp_q.size() >= DEPTH;
    exp_en   = active && !ht && (DROP || !full_now);
    exp_busy = (mode != MIdle);
    exp_done = (mode == MDone);
    rec      = {cnt, state_in, pc_in, instr_in};
    @(posedge clk);
    if (!rb) begin
      mode = MIdle;
      remaining = 0;
      cnt = 16'd0;
      ovf = 1'b0;
      exp_q.delete();
    end else begin
      if (exp_en) begin
        if (!full_now) exp_q.push_back(rec);
        else ovf = 1'b1;
        cnt = cnt + 16'd1;
      end
      case (mode)
        MIdle: begin
          if (st) begin
            if (n == 0) mode = MDone;
            else begin
              mode = MRun;
              remaining = n;
            end
          end else if (sp) mode = MStep;
        end
        MRun: begin
          if (ht) mode = MDone;
          else if (exp_en) begin
            remaining--;
            if (remaining == 0) mode = MDone;
          end
        end
        MStep: if (ht || exp_en) mode = MDone;
        default: mode = MIdle;
      endcase
    end
    #1;
  endtask

  task automatic idle(input int k, input bit rdy);
    for (int i = 0; i < k; i++) tick(0, 0, 0, 0, rdy, 1);
  endtask

  task automatic drain(input int limit);
    int k = 0;
    while ((mode != MIdle || exp_q.size() != 0) && k < limit) begin
      tick(0, 0, 0, 0, 1, 1);
      k++;
    end
    if (mode != MIdle || exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    idle(2, 1);
  endtask

  task automatic do_reset();
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    en_seen = 0;
    rec_seen = 0;
    done_seen = 0;
  endtask

  initial begin
    int en_cnt;
    int k;
    rstb = 1'b0;
    start = 1'b0;
    step = 1'b0;
    halt = 1'b0;
    num_cycles = 16'd0;
    rif.rec_ready = 1'b0;
    state_in = '0;
    pc_in = '0;
    instr_in = '0;

    tick(0, 0, 0, 0, 0, 0);
    armed = 1'b1;
    do_reset();
    idle(2, 0);

    // Short run with a ready consumer.
    en_seen = 0; rec_seen = 0; done_seen = 0;
    tick(1, 5, 0, 0, 1, 1);
    drain(100);
    check("run5_en", en_seen, 5);
    check("run5_recs", rec_seen, 5);
    check("run5_done", done_seen, 1);

    // Backpressure longer than the FIFO depth.
    do_reset();
    tick(1, 40, 0, 0, 0, 1);
    idle(45, 0);
    check("bp_en_before_ready", en_seen, DROP ? 40 : 16);
    drain(200);
    check("bp_en_total", en_seen, 40);
    check("bp_recs", rec_seen, DROP ? 16 : 40);
    check("bp_overflow", overflow, DROP);

    // Three single steps spaced 4 cycles apart.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0, 1, 1);
      idle(3, 1);
    end
    drain(50);
    check("step_en", en_seen, 3);
    check("step_recs", rec_seen, 3);
    check("step_done", done_seen, 3);

    // Halt on the 10th enabled cycle; a second start during the run is ignored.
    do_reset();
    tick(1, 100, 0, 0, 1, 1);
    en_cnt = 0;
    k = 0;
    while (k < 200) begin
      bit h;
      h = (en_cnt == 9);
      tick(k == 3, 7, 0, h, 1, 1);
      if (exp_en) en_cnt++;
      k++;
      if (h) break;
    end
    drain(50);
    check("halt_en", en_seen, 9);
    check("halt_recs", rec_seen, 9);
    check("halt_done", done_seen, 1);

    // Reset with 7 records pending, then a one-cycle run and a zero-length run.
    do_reset();
    tick(1, 20, 0, 0, 0, 1);
    k = 0;
    while (exp_q.size() < 7 && k < 50) begin
      tick(0, 0, 0, 0, 0, 1);
      k++;
    end
    check("pending7", exp_q.size(), 7);
    tick(0, 0, 0, 0, 0, 0);
    en_seen = 0; rec_seen = 0; done_seen = 0;
    tick(1, 1, 0, 0, 1, 1);
    drain(50);
    check("one_en", en_seen, 1);
    check("one_recs", rec_seen, 1);
    tick(1, 0, 0, 0, 1, 1);
    drain(20);
    check("zero_en", en_seen, 1);
    check("zero_done", done_seen, 2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 24), $urandom_range(0, 5) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 249) != 0);
    end
    drain(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
